// File: rtl/ppm_pkg.sv
// ppm_pkg: order codes and default timing/depth shared by the frame scheduler and the PPM transmitter.
package ppm_pkg;
   typedef enum logic [1:0] {
      ORD_IDLE = 2'b00,
      ORD_SOF  = 2'b01,
      ORD_DATA = 2'b10,
      ORD_EOF  = 2'b11
   } order_t;
   localparam int PPM_DEPTH      = 16;
   localparam int PPM_SYM_CYCLES = 128;
   localparam int PPM_EOF_CYCLES = 64;
endpackage

// File: rtl/ppm_byte_fifo.sv
// ppm_byte_fifo: DEPTH x 8 circular byte buffer with write, pop, head and occupancy level.
module ppm_byte_fifo
   import ppm_pkg::*;
#(
   parameter int DEPTH = PPM_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] wr_data,
   input  logic       wr_en,
   input  logic       pop,
   output logic [7:0] head,
   output logic [4:0] level,
   output logic       full
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [4:0]    count;
   logic          do_wr, do_pop;
   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign full   = count == 5'(DEPTH);
   assign do_wr  = wr_en && !full;
   assign do_pop = pop && count != 5'd0;
   assign head   = mem[rd_ptr];
   assign level  = count;
   // Storage carries no reset; only pointers and occupancy define validity.
   always_ff @(posedge clk)
      if (do_wr) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= inc(wr_ptr);
         if (do_pop) rd_ptr <= inc(rd_ptr);
         count <= count + 5'(do_wr) - 5'(do_pop);
      end
endmodule

// File: rtl/ppm_frame_scheduler.sv
// ppm_frame_scheduler: buffers bytes and sequences SOF, 2-bit PPM data symbols and EOF
// commands for the transmitter, one frame per start request.
module ppm_frame_scheduler
   import ppm_pkg::*;
#(
   parameter int DEPTH      = PPM_DEPTH,
   parameter int SYM_CYCLES = PPM_SYM_CYCLES,
   parameter int EOF_CYCLES = PPM_EOF_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       start,
   output logic [1:0] order,
   output logic [9:0] clk_count,
   output logic [1:0] bit_count,
   output logic [7:0] tx_byte,
   output logic       busy,
   output logic       frame_done,
   output logic [4:0] level
);
   order_t     state, state_nxt;
   logic [9:0] cnt_nxt;
   logic [1:0] bit_nxt;
   logic [4:0] bytes_left, bytes_left_nxt;
   logic [7:0] head;
   logic       full, load, done_nxt, sym_end, eof_end, last_seg, last_byte;
   ppm_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data (in_data),
      .wr_en   (in_valid),
      .pop     (load),
      .head    (head),
      .level   (level),
      .full    (full)
   );
   assign in_ready  = !full;
   assign order     = state;
   assign sym_end   = clk_count == 10'(SYM_CYCLES - 1);
   assign eof_end   = clk_count == 10'(EOF_CYCLES - 1);
   assign last_seg  = bit_count == 2'd3;
   assign last_byte = bytes_left == 5'd1;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= ORD_IDLE;
         clk_count  <= '0;
         bit_count  <= '0;
         tx_byte    <= '0;
         bytes_left <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         clk_count  <= cnt_nxt;
         bit_count  <= bit_nxt;
         tx_byte    <= load ? head : tx_byte;
         bytes_left <= bytes_left_nxt;
         busy       <= state_nxt != ORD_IDLE;
         frame_done <= done_nxt;
      end
   always_comb begin
      state_nxt = state;
      unique case (state)
         ORD_IDLE: if (start && level != 5'd0) state_nxt = ORD_SOF;
         ORD_SOF:  if (sym_end) state_nxt = ORD_DATA;
         ORD_DATA: if (sym_end && last_seg && last_byte) state_nxt = ORD_EOF;
         ORD_EOF:  if (eof_end) state_nxt = ORD_IDLE;
      endcase
   end
   // A byte is fetched on SOF exit and after the last segment of every non-final byte.
   always_comb begin
      load           = sym_end && (state == ORD_SOF || (state == ORD_DATA && last_seg && !last_byte));
      done_nxt       = state == ORD_EOF && eof_end;
      cnt_nxt        = (state == ORD_IDLE || state_nxt == ORD_IDLE || (state != ORD_EOF && sym_end))
                       ? 10'd0 : clk_count + 10'd1;
      bit_nxt        = state != ORD_DATA ? 2'd0 : sym_end ? bit_count + 2'd1 : bit_count;
      bytes_left_nxt = state == ORD_IDLE && state_nxt == ORD_SOF ? level
                     : state == ORD_DATA && load ? bytes_left - 5'd1 : bytes_left;
   end
endmodule

// File: tb/tb_ppm_frame_scheduler.sv
// tb_ppm_frame_scheduler: scoreboard bench; queued bytes and frame lengths are checked as the DUT emits them.
module tb_ppm_frame_scheduler;
   localparam int SYM = 128;
   localparam int EOFC = 64;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       start = 1'b0;
   logic [1:0] order;
   logic [9:0] clk_count;
   logic [1:0] bit_count;
   logic [7:0] tx_byte;
   logic       busy;
   logic       frame_done;
   logic [4:0] level;
   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         sof_cyc = 0;
   int         done_cnt = 0;
   logic [1:0] seg_exp = '0;
   logic [7:0] sbq[$];
   int         lenq[$];
   ppm_frame_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .start      (start),
      .order      (order),
      .clk_count  (clk_count),
      .bit_count  (bit_count),
      .tx_byte    (tx_byte),
      .busy       (busy),
      .frame_done (frame_done),
      .level      (level)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // Monitor: compare emitted bytes, segment order and frame lengths against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (order == 2'b01 && clk_count == 10'd0) begin
            sof_cyc = cyc;
            seg_exp = 2'd0;
         end
         if (order == 2'b10 && clk_count == 10'd0) begin
            check("bit_count", 32'(bit_count), 32'(seg_exp));
            seg_exp = seg_exp + 2'd1;
            if (bit_count == 2'd0) begin
               if (sbq.size() == 0) check("tx_unexpected", 32'(tx_byte), 32'hFFFF);
               else check("tx_byte", 32'(tx_byte), 32'(sbq.pop_front()));
            end
         end
         if (frame_done) begin
            done_cnt++;
            if (lenq.size() == 0) check("done_unexpected", 1, 0);
            else check("frame_len", cyc - sof_cyc, lenq.pop_front());
         end
      end
   end
   task automatic push(input logic [7:0] b, input bit chk, input bit exp_rdy);
      if (chk) check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (in_ready) sbq.push_back(b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask
   task automatic kick();
      lenq.push_back(SYM + 4 * SYM * sbq.size() + EOFC);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("order_sof", 32'(order), 32'd1);
      check("busy_sof", 32'(busy), 32'd1);
   endtask
   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         seen = frame_done;
      end
      check("done_seen", 32'(seen), 32'd1);
      tick();
      check("done_pulse", 32'(frame_done), 32'd0);
      check("idle_order", 32'(order), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
   endtask
   task automatic wait_data(input logic [1:0] bc, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         seen = order == 2'b10 && bit_count == bc;
      end
      check("wait_data", 32'(seen), 32'd1);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int d0;
      repeat (3) tick();
      check("rst_order", 32'(order), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_tx_byte", 32'(tx_byte), 32'd0);
      rst = 1'b1;
      tick();
      // Single byte frame
      push(8'hB4, 1'b1, 1'b1);
      check("level_one", 32'(level), 32'd1);
      kick();
      wait_done(800);
      check("level_after_single", 32'(level), 32'd0);
      // Full buffer, overflow dropped
      for (int i = 0; i < 16; i++) push(8'(i), 1'b1, 1'b1);
      push(8'hFF, 1'b1, 1'b0);
      check("level_full", 32'(level), 32'd16);
      kick();
      wait_done(9000);
      check("level_after_full", 32'(level), 32'd0);
      // Start with empty buffer
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check("empty_order", 32'(order), 32'd0);
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_done", 32'(done_cnt), 32'(d0));
      // Write during a frame stays for the next one
      push(8'h11, 1'b1, 1'b1);
      push(8'h22, 1'b1, 1'b1);
      kick();
      sbq.push_back(8'h55);
      sbq.pop_back();
      wait_data(2'd0, 300);
      push(8'h55, 1'b0, 1'b1);
      lenq.delete();
      lenq.push_back(SYM + 4 * SYM * 2 + EOFC);
      wait_done(1500);
      check("level_mid_write", 32'(level), 32'd1);
      kick();
      wait_done(800);
      check("level_after_55", 32'(level), 32'd0);
      // Reset in the middle of a data symbol
      push(8'h77, 1'b1, 1'b1);
      push(8'h88, 1'b1, 1'b1);
      kick();
      wait_data(2'd2, 800);
      #3 rst = 1'b0;
      #1;
      check("arst_order", 32'(order), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_level", 32'(level), 32'd0);
      check("arst_clk_count", 32'(clk_count), 32'd0);
      check("arst_tx_byte", 32'(tx_byte), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      sbq.delete();
      lenq.delete();
      d0 = done_cnt;
      repeat (2) tick();
      rst = 1'b1;
      repeat (800) tick();
      check("arst_no_done", 32'(done_cnt), 32'(d0));
      check("arst_idle", 32'(order), 32'd0);
      check("sb_drained", 32'(sbq.size() + lenq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ppm_frame_scheduler.md
PPM_FRAME_SCHEDULER -- requirements
Module: ppm_frame_scheduler

Interface
REQ-001 Parameters: DEPTH, default 16, byte-buffer entries.
REQ-002 Parameters: SYM_CYCLES, default 128, clocks per SOF and per 2-bit data symbol.
REQ-003 Parameters: EOF_CYCLES, default 64, clocks per EOF.
REQ-004 Port: clk, in, 1, sole clock; all logic on its rising edge.
REQ-005 Port: rst, in, 1, asynchronous active-low reset.
REQ-006 Port: in_data, in, 8, byte to enqueue.
REQ-007 Port: in_valid, in, 1, in_data valid.
REQ-008 Port: in_ready, out, 1, buffer can accept (level < DEPTH).
REQ-009 Port: start, in, 1, request transmission of one frame.
REQ-010 Port: order, out, 2, transmitter command: 00 IDLE, 01 SOF, 10 DATA, 11 EOF.
REQ-011 Port: clk_count, out, 10, cycle index within current SOF/symbol/EOF.
REQ-012 Port: bit_count, out, 2, 2-bit segment index of tx_byte, LSB segment first.
REQ-013 Port: tx_byte, out, 8, byte currently being transmitted.
REQ-014 Port: busy, out, 1, high while order != IDLE.
REQ-015 Port: frame_done, out, 1, one-cycle pulse at frame end.
REQ-016 Port: level, out, 5, buffer occupancy 0..DEPTH.

Function
REQ-017 Write occurs on a cycle with in_valid && in_ready; writes are accepted in every state, including mid-frame.
REQ-018 in_valid while full is dropped: no write, level unchanged.
REQ-019 Simultaneous write and pop leaves level unchanged; the buffer is circular and pointers wrap modulo DEPTH.
REQ-020 FSM states IDLE, SOF, DATA, EOF; order equals the state encoding.
REQ-021 In IDLE, start with level > 0 latches bytes_left = level and enters SOF next cycle with clk_count = 0.
REQ-022 start is ignored when level = 0 or when busy = 1.
REQ-023 clk_count increments every cycle in SOF, DATA and EOF, and is 0 in IDLE.
REQ-024 SOF at clk_count = SYM_CYCLES-1: go to DATA, clk_count 0, bit_count 0, tx_byte <= head, pop.
REQ-025 DATA at clk_count = SYM_CYCLES-1 with bit_count < 3: bit_count + 1, clk_count 0.
REQ-026 DATA at clk_count = SYM_CYCLES-1 with bit_count = 3 and bytes_left > 1: bytes_left - 1, bit_count 0, tx_byte <= head, pop.
REQ-027 DATA at clk_count = SYM_CYCLES-1 with bit_count = 3 and bytes_left = 1: go to EOF, clk_count 0.
REQ-028 EOF at clk_count = EOF_CYCLES-1: go to IDLE, frame_done = 1 for exactly that next cycle.
REQ-029 Frame length is SYM_CYCLES + 4*SYM_CYCLES*N + EOF_CYCLES clocks (N = latched bytes).
REQ-030 Bytes written after start are not part of the current frame.
REQ-031 All outputs are registered, except in_ready and level, which derive combinationally from the occupancy register.

Reset
REQ-032 On rst low, immediately: order 00, clk_count 0, bit_count 0, tx_byte 00, busy 0, frame_done 0, level 0, pointers 0.
REQ-033 Reset mid-frame aborts the frame with no frame_done, and the buffer is emptied.

Structure
REQ-034 Shared package ppm_pkg holds order codes (IDLE/SOF/DATA/EOF), SYM_CYCLES, EOF_CYCLES and DEPTH, used by this block and by the transmitter.
REQ-035 One sub-module, ppm_byte_fifo, holds the buffer: DEPTH x 8 circular buffer with write, pop, head and level.
REQ-036 The FSM and counters live in ppm_frame_scheduler.

Verification
REQ-037 Reset: assert rst -> order 00, busy 0, level 0, in_ready 1, tx_byte 00.
REQ-038 Single byte: push 0xB4, pulse start -> SOF for 128 cycles; then DATA with tx_byte B4 and bit_count 0,1,2,3 for 128 cycles each; then EOF for 64 cycles; frame_done 704 cycles after SOF entry; level 0.
REQ-039 Full buffer: push 16 bytes 0x00..0x0F, then in_valid with 0xFF -> in_ready 0, 0xFF dropped; start -> tx_byte sequence 00..0F, frame 8384 cycles.
REQ-040 Empty start: start with level 0 -> order stays 00, busy 0, no frame_done.
REQ-041 Mid-frame write: push 0x11, 0x22, start, push 0x55 during DATA -> frame carries 0x11, 0x22 only; level 1 after frame_done; second start sends 0x55.
REQ-042 Mid-frame reset: assert rst at DATA bit_count 2 -> order 00 asynchronously, level 0, no frame_done after release.
